// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//   Front end of the core. Holds the PC and issues one instruction-memory read
//   per cycle whenever the fetch buffer has room for the response. It queues
//   the returned words, tagged with their PCs, in a small in-order FIFO and
//   presents the FIFO head to the datapath with a valid/ready handshake. A
//   taken branch flushes everything buffered or in flight and restarts
//   fetching at the word-aligned target.
//
// Parameters:
//   RESET_PC    address of the first fetch after reset
//   FIFO_DEPTH  fetch buffer entries (2 or 4)
//
// Ports:
//   clk                 single clock, rising-edge
//   rst_n               synchronous active-low reset
//   imem_req            instruction memory read strobe
//   imem_addr    [63:0] read address (equals the PC, word aligned)
//   imem_rdata   [31:0] read data, valid the cycle after its imem_req
//   branch_taken        redirect request from the datapath
//   branch_target[63:0] redirect address, qualified by branch_taken
//   out_valid           head instruction is presented
//   out_ready           datapath accepts the head this cycle
//   instructionAddress  PC of the head instruction (0 when not valid)
//   instruction  [31:0] head instruction word (0 when not valid)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] instructionAddress,
  output logic [31:0] instruction
);

  localparam int         PTR_W = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

  logic [63:0]      pc;
  logic             inflight;       // a non-cancelled request was issued last cycle
  logic [63:0]      inflight_addr;  // PC of that request, used as the FIFO tag
  logic [2:0]       count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [63:0]      addr_mem [FIFO_DEPTH];
  logic [31:0]      data_mem [FIFO_DEPTH];

  logic             pop;
  logic             push;
  logic [3:0]       occupancy;

  // A response is only kept if its request was not cancelled and no redirect
  // is discarding it in this very cycle.
  assign pop       = out_valid & out_ready;
  assign push      = inflight & ~branch_taken;

  // Entries that will be committed after this edge. Counting the pop lets a
  // full buffer keep streaming at one word per cycle, which is why imem_req
  // depends combinationally on out_ready. pop implies count >= 1, so this
  // never underflows.
  assign occupancy = {1'b0, count} + {3'b000, inflight} - {3'b000, pop};

  assign imem_req  = rst_n & ~branch_taken & (occupancy < {1'b0, DEPTH});
  assign imem_addr = pc;
  assign out_valid = rst_n & (count != 3'd0);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    instructionAddress = '0;
    instruction        = '0;
    if (out_valid) begin
      instructionAddress = addr_mem[rd_ptr];
      instruction        = data_mem[rd_ptr];
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC & ~64'd3;
      inflight      <= 1'b0;
      inflight_addr <= '0;
      count         <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
    end else if (branch_taken) begin
      // Redirect: drop buffered and in-flight words and restart at the target.
      // A handshake in this cycle has already completed at the datapath side.
      pc       <= branch_target & ~64'd3;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        pc            <= pc + 64'd4;  // wraps modulo 2^64
        inflight_addr <= pc;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count and the pointers alone decide
  // which entries are meaningful, so clearing the data would only add logic.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      addr_mem[wr_ptr] <= inflight_addr;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Two instances: the main one (RESET_PC=0, FIFO_DEPTH=2) covers reset, cold
// start, backpressure, redirects and mid-run reset; the second one
// (RESET_PC=...FFF8, FIFO_DEPTH=4) covers the address wrap. The memory model
// answers every request one cycle later with word = addr[31:0] + 32'h1000.
// A scoreboard queue receives the expected {addr, word} for each request the
// bench model predicts; it is popped on every handshake and cleared on reset
// and redirect.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] ia;
  logic [31:0] instr;

  logic        w_rst_n;
  logic        w_imem_req;
  logic [63:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_branch_taken;
  logic [63:0] w_branch_target;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_ia;
  logic [31:0] w_instr;

  int          total = 0;
  int          bad   = 0;
  entry_t      sb_q[$];
  logic [63:0] exp_issue;
  logic        mem_req_q, w_mem_req_q;
  logic [63:0] mem_addr_q, w_mem_addr_q;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

  instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_rdata        (imem_rdata),
    .branch_taken      (branch_taken),
    .branch_target     (branch_target),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .instructionAddress(ia),
    .instruction       (instr)
  );

  instruction_fetch #(.RESET_PC(WRAP_PC), .FIFO_DEPTH(4)) dut_wrap (
    .clk               (clk),
    .rst_n             (w_rst_n),
    .imem_req          (w_imem_req),
    .imem_addr         (w_imem_addr),
    .imem_rdata        (w_imem_rdata),
    .branch_taken      (w_branch_taken),
    .branch_target     (w_branch_target),
    .out_valid         (w_out_valid),
    .out_ready         (w_out_ready),
    .instructionAddress(w_ia),
    .instruction       (w_instr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word_for(input logic [63:0] a);
    return a[31:0] + 32'h1000;
  endfunction

  // Sample in the middle of the cycle and run the scoreboard.
  task automatic settle();
    entry_t e;
    @(negedge clk);
    mem_req_q    = imem_req;
    mem_addr_q   = imem_addr;
    w_mem_req_q  = w_imem_req;
    w_mem_addr_q = w_imem_addr;
    if (!rst_n) begin
      sb_q.delete();
      exp_issue = 64'h0;
    end else begin
      if (out_valid && out_ready) begin
        total++;
        if (sb_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: delivered addr=%h instr=%h, expected no delivery", ia, instr);
        end else begin
          e = sb_q.pop_front();
          if (ia !== e.addr || instr !== e.data) begin
            bad++;
            $display("FAIL sb_head: got addr=%h instr=%h, expected addr=%h instr=%h",
                     ia, instr, e.addr, e.data);
          end
        end
      end
      if (branch_taken) begin
        total++;
        if (imem_req !== 1'b0) begin
          bad++;
          $display("FAIL sb_req_in_redirect: imem_req=%b, expected 0", imem_req);
        end
        sb_q.delete();
        exp_issue = branch_target & ~64'd3;
      end else if (imem_req) begin
        total++;
        if (imem_addr !== exp_issue) begin
          bad++;
          $display("FAIL sb_issue_addr: imem_addr=%h, expected %h", imem_addr, exp_issue);
        end
        e.addr = exp_issue;
        e.data = word_for(exp_issue);
        sb_q.push_back(e);
        exp_issue = exp_issue + 64'd4;
      end
      if (!out_valid) begin
        total++;
        if (ia !== 64'h0 || instr !== 32'h0) begin
          bad++;
          $display("FAIL sb_idle_zero: addr=%h instr=%h, expected 0 while out_valid=0", ia, instr);
        end
      end
    end
  endtask

  // Step to the next cycle and drive the memory responses for it.
  task automatic advance();
    @(posedge clk);
    #1;
    imem_rdata   = mem_req_q   ? word_for(mem_addr_q)   : 32'hDEAD_BEEF;
    w_imem_rdata = w_mem_req_q ? word_for(w_mem_addr_q) : 32'hDEAD_BEEF;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    settle();
    advance();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    branch_taken = 1'b0;
    for (int c = 0; c < 3; c++) begin
      settle();
      total++;
      if (imem_req !== 1'b0 || out_valid !== 1'b0 || ia !== 64'h0 || instr !== 32'h0) begin
        bad++;
        $display("FAIL reset_outputs: req=%b valid=%b addr=%h instr=%h, expected all 0",
                 imem_req, out_valid, ia, instr);
      end
      advance();
    end
  endtask

  task automatic test_cold_start();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      settle();
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 64'(c * 4)) begin
        bad++;
        $display("FAIL cold_issue c%0d: req=%b addr=%h, expected req=1 addr=%h",
                 c, imem_req, imem_addr, 64'(c * 4));
      end
      total++;
      if (c < 2) begin
        if (out_valid !== 1'b0) begin
          bad++;
          $display("FAIL cold_fill c%0d: out_valid=%b, expected 0", c, out_valid);
        end
      end else if (out_valid !== 1'b1 || ia !== 64'((c - 2) * 4) ||
                   instr !== word_for(64'((c - 2) * 4))) begin
        bad++;
        $display("FAIL cold_stream c%0d: valid=%b addr=%h instr=%h, expected valid=1 addr=%h instr=%h",
                 c, out_valid, ia, instr, 64'((c - 2) * 4), word_for(64'((c - 2) * 4)));
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      out_ready = (c < 2);
      settle();
      total++;
      if (c < 2) begin
        if (imem_req !== 1'b1 || imem_addr !== 64'(c * 4)) begin
          bad++;
          $display("FAIL bp_fill c%0d: req=%b addr=%h, expected req=1 addr=%h",
                   c, imem_req, imem_addr, 64'(c * 4));
        end
      end else if (imem_req !== 1'b0 || out_valid !== 1'b1 || ia !== 64'h0 ||
                   instr !== 32'h1000) begin
        bad++;
        $display("FAIL bp_stall c%0d: req=%b valid=%b addr=%h instr=%h, expected req=0 valid=1 addr=0 instr=1000",
                 c, imem_req, out_valid, ia, instr);
      end
      advance();
    end
    for (int c = 0; c < 6; c++) begin
      out_ready = 1'b1;
      settle();
      total++;
      if (out_valid !== 1'b1 || ia !== 64'(c * 4) || imem_req !== 1'b1 ||
          imem_addr !== 64'(8 + c * 4)) begin
        bad++;
        $display("FAIL bp_release c%0d: valid=%b head=%h req=%b issue=%h, expected valid=1 head=%h req=1 issue=%h",
                 c, out_valid, ia, imem_req, imem_addr, 64'(c * 4), 64'(8 + c * 4));
      end
      advance();
    end
  endtask

  // Shared check of the post-redirect timeline, k counted from the cycle
  // after the last redirect cycle.
  task automatic check_after_redirect(input string tag, input logic [63:0] tgt, input int k);
    total++;
    if (k == 1) begin
      if (imem_req !== 1'b1 || imem_addr !== tgt || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s k1: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                 tag, imem_req, imem_addr, out_valid, tgt);
      end
    end else if (k == 2) begin
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL %s k2: out_valid=%b, expected 0", tag, out_valid);
      end
    end else if (out_valid !== 1'b1 || ia !== tgt + 64'(4 * (k - 3)) ||
                 instr !== word_for(tgt + 64'(4 * (k - 3)))) begin
      bad++;
      $display("FAIL %s k%0d: valid=%b addr=%h instr=%h, expected valid=1 addr=%h",
               tag, k, out_valid, ia, instr, tgt + 64'(4 * (k - 3)));
    end
  endtask

  task automatic test_redirect();
    out_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 64'h103;
    settle();
    advance();
    branch_taken = 1'b0;
    branch_target = 64'hDEAD_0000;
    for (int k = 1; k <= 6; k++) begin
      settle();
      check_after_redirect("redirect", 64'h100, k);
      advance();
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    branch_taken = 1'b1;
    branch_target = 64'h200;
    settle();
    advance();
    branch_target = 64'h305;
    settle();
    advance();
    branch_taken = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      settle();
      check_after_redirect("b2b", 64'h304, k);
      advance();
    end
  endtask

  task automatic test_full_redirect();
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      advance();
    end
    settle();
    total++;
    if (out_valid !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL full_state: valid=%b req=%b, expected valid=1 req=0", out_valid, imem_req);
    end
    advance();
    branch_taken = 1'b1;
    branch_target = 64'h400;
    settle();
    advance();
    branch_taken = 1'b0;
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      settle();
      check_after_redirect("full_redirect", 64'h400, k);
      advance();
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      advance();
    end
    rst_n = 1'b0;
    settle();
    total++;
    if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_hold: req=%b valid=%b, expected 0 0", imem_req, out_valid);
    end
    advance();
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      settle();
      total++;
      if (k < 2) begin
        if (out_valid !== 1'b0 || (k == 0 && (imem_req !== 1'b1 || imem_addr !== 64'h0))) begin
          bad++;
          $display("FAIL mid_reset_restart k%0d: valid=%b req=%b addr=%h, expected valid=0 (k0: req=1 addr=0)",
                   k, out_valid, imem_req, imem_addr);
        end
      end else if (out_valid !== 1'b1 || ia !== 64'(4 * (k - 2))) begin
        bad++;
        $display("FAIL mid_reset_stream k%0d: valid=%b addr=%h, expected valid=1 addr=%h",
                 k, out_valid, ia, 64'(4 * (k - 2)));
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [63:0] exp_req;
    logic [63:0] exp_head;
    w_rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      settle();
      exp_req = WRAP_PC + 64'(4 * k);
      total++;
      if (w_imem_req !== 1'b1 || w_imem_addr !== exp_req) begin
        bad++;
        $display("FAIL wrap_issue k%0d: req=%b addr=%h, expected req=1 addr=%h",
                 k, w_imem_req, w_imem_addr, exp_req);
      end
      if (k >= 2) begin
        exp_head = WRAP_PC + 64'(4 * (k - 2));
        total++;
        if (w_out_valid !== 1'b1 || w_ia !== exp_head || w_instr !== word_for(exp_head)) begin
          bad++;
          $display("FAIL wrap_head k%0d: valid=%b addr=%h instr=%h, expected valid=1 addr=%h instr=%h",
                   k, w_out_valid, w_ia, w_instr, exp_head, word_for(exp_head));
        end
      end
      advance();
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_rdata      = 32'hDEAD_BEEF;
    branch_taken    = 1'b0;
    branch_target   = 64'h0;
    out_ready       = 1'b1;
    w_rst_n         = 1'b0;
    w_imem_rdata    = 32'hDEAD_BEEF;
    w_branch_taken  = 1'b0;
    w_branch_target = 64'h0;
    w_out_ready     = 1'b1;
    exp_issue       = 64'h0;
    mem_req_q       = 1'b0;
    mem_addr_q      = 64'h0;
    w_mem_req_q     = 1'b0;
    w_mem_addr_q    = 64'h0;

    test_reset();
    test_cold_start();
    test_backpressure();
    test_redirect();
    test_back_to_back();
    test_full_redirect();
    test_mid_reset();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0: address of the first fetch after reset.
REQ-002 Parameter FIFO_DEPTH, default 2: fetch buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 imem_req  output  1  instruction memory read strobe.
REQ-006 imem_addr  output  64  instruction memory read address; bits [1:0] always 0.
REQ-007 imem_rdata  input  32  instruction word; valid in the cycle after its imem_req.
REQ-008 branch_taken  input  1  redirect request from the datapath.
REQ-009 branch_target  input  64  redirect address; qualified by branch_taken.
REQ-010 out_valid  output  1  the head instruction is presented to the datapath.
REQ-011 out_ready  input  1  the datapath accepts the head this cycle.
REQ-012 instructionAddress  output  64  PC of the head instruction; drives the datapath instructionAddress port.
REQ-013 instruction  output  32  head instruction word.

Function
REQ-014 The PC register SHALL hold the next fetch address and SHALL advance by 4 on each issued imem_req, wrapping modulo 2^64.
REQ-015 imem_addr SHALL equal the PC; imem_req SHALL be high iff branch_taken=0 and (count + inflight - pop) < FIFO_DEPTH.
REQ-016 In REQ-015, count = FIFO occupancy; inflight = 1 when the previous cycle issued a request that was not cancelled, else 0; pop = out_valid & out_ready. imem_req therefore depends combinationally on out_ready.
REQ-017 Latency: a request issued in cycle N SHALL be written into the FIFO at the end of cycle N+1, tagged with its address. It SHALL be presented with out_valid=1 no earlier than cycle N+2.
REQ-018 Throughput: with out_ready held high and no redirect, one instruction SHALL be delivered per cycle with no bubbles after the initial fill.
REQ-019 out_valid SHALL equal (count != 0). instructionAddress and instruction SHALL reflect the FIFO head, and SHALL be 0 while out_valid=0.
REQ-020 A handshake (out_valid & out_ready) SHALL remove the head at the clock edge. The FIFO SHALL be strict in-order.
REQ-021 A push and a pop in the same cycle SHALL leave count unchanged. A push into a full FIFO SHALL be impossible by construction of REQ-015.
REQ-022 Redirect: when branch_taken=1 in cycle T, the following SHALL happen at the end of T:
  - PC <= {branch_target[63:2], 2'b00};
  - all FIFO entries are flushed;
  - any response arriving in cycle T is discarded;
  - inflight <= 0.
REQ-023 A handshake occurring in redirect cycle T SHALL still count as a completed transfer.
REQ-024 After a redirect in cycle T, out_valid SHALL be 0 in cycles T+1 and T+2. The first request SHALL issue in T+1 with imem_addr equal to the aligned target, and its instruction SHALL be presented in T+3.
REQ-025 Back-to-back redirects in consecutive cycles SHALL each take effect; the last one wins.
REQ-026 Address wrap from 64'hFFFF_FFFF_FFFF_FFFC SHALL continue fetching at 64'h0.

Reset
REQ-027 While rst_n=0 at a rising edge, the block SHALL set PC <= RESET_PC, count <= 0 and inflight <= 0.
REQ-028 While rst_n=0, imem_req and out_valid SHALL be 0, and instructionAddress and instruction SHALL be 0.
REQ-029 The first imem_req SHALL occur in the first cycle with rst_n=1, using address RESET_PC.
REQ-030 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions; no pre-reset instruction SHALL appear afterwards.

Verification
REQ-031 Cold start: RESET_PC=0, out_ready=1, imem returns word = addr+32'h1000.
  - First rst_n=1 cycle C0 issues addr 0.
  - out_valid rises in C2 with instructionAddress=0, instruction=32'h1000.
  - Addresses 4, 8, 12 then follow on consecutive cycles.
REQ-032 Backpressure: out_ready=0 from C2.
  - imem_req drops once count+inflight=FIFO_DEPTH.
  - Head stays at addr 0 and no entry is lost or duplicated.
  - Releasing out_ready delivers 0, 4, 8, ... in order.
REQ-033 Redirect: branch_taken=1 with branch_target=64'h103 in cycle T.
  - imem_addr=64'h100 in T+1.
  - out_valid=0 in T+1 and T+2.
  - instructionAddress=64'h100 in T+3.
  - No pre-T sequential address appears after T.
REQ-034 Redirect with full FIFO and out_ready=0: all entries flushed; the next delivered address is the target.
REQ-035 Mid-run reset: deassert rst_n for one cycle during streaming.
  - out_valid=0 the cycle after the reset edge.
  - Fetch restarts at RESET_PC with no stale words.
REQ-036 Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 delivers addresses ...FFF8, ...FFFC, 0, 4.
